imu_burst_reader: RTL

IMU_BURST_READER -- requirements
Module: imu_burst_reader

---
 rtl/imu_burst_reader_if.sv | 24 ++
 rtl/imu_burst_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imu_burst_reader_if.sv
// Signal bundle between the IMU burst reader, its host controller and the SPI byte engine.
interface imu_burst_reader_if #(parameter int NUM_AXES = 3);
   logic                    start;
   logic                    interrupt;
   logic                    end_transmission;
   logic                    chip_select;
   logic [7:0]              received_data;
   logic                    begin_transmission;
   logic [7:0]              send_data;
   logic                    done_init;
   logic                    done_read;
   logic [16*NUM_AXES-1:0]  axis_data;
   logic                    overrun;

   modport master (
      input  start, interrupt, end_transmission, chip_select, received_data,
      output begin_transmission, send_data, done_init, done_read, axis_data, overrun
   );

   modport slave (
      output start, interrupt, end_transmission, chip_select, received_data,
      input  begin_transmission, send_data, done_init, done_read, axis_data, overrun
   );
endinterface

// File: rtl/imu_burst_reader.sv
// IMU sequencer: writes a register init table, then performs interrupt-driven burst reads.
// Defining IMU_SAMPLE_COUNT_EN adds a wrapping 16-bit sample_count output.
module imu_burst_reader #(
   parameter int            NUM_AXES   = 3,
   parameter int            INIT_LEN   = 4,
   parameter logic [127:0]  INIT_TABLE = 128'h0000_0000_0000_0000_2402_2330_2208_200F,
   parameter logic [7:0]    READ_ADDR  = 8'hE8,
   parameter bit            BIG_ENDIAN = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   imu_burst_reader_if.master bus
`ifdef IMU_SAMPLE_COUNT_EN
   ,
   output logic [15:0]       sample_count
`endif
);

   // state     | meaning
   // IDLE      | bus idle, results cleared, waiting for start
   // INIT_LOAD | pick next init entry or finish init
   // SEND_ADDR | frame open, shifting address / command byte
   // SEND_DATA | shifting init data byte
   // READ_BYTE | shifting dummy bytes, capturing sensor bytes
   // LATCH     | burst result published, done_read pulse
   // WAIT_CS   | frame closed, waiting for byte engine to release CS
   // RUN       | idle between bursts, waiting for data-ready

   localparam int NBYTES = 2 * NUM_AXES;
   localparam int AW     = 16 * NUM_AXES;

   typedef enum logic [2:0] {
      IDLE, INIT_LOAD, SEND_ADDR, SEND_DATA, READ_BYTE, LATCH, WAIT_CS, RUN
   } state_t;

   state_t              state, state_n;
   logic [3:0]          idx, idx_n;
   logic [2:0]          slot, slot_n;
   logic                rd_frame, rd_frame_n;
   logic [8*NBYTES-1:0] byte_buf, byte_buf_n;
   logic [AW-1:0]       axis_q, axis_n;
   logic                done_init_q, done_init_n;
   logic                pending, pending_n;
   logic                overrun_q, overrun_n;
   logic                int_q;
   logic                bt, dr;
   logic [7:0]          sd;
   logic [15:0]         entry;
   logic                irq_edge, read_busy, last_slot;

   assign entry     = INIT_TABLE[16*idx[2:0] +: 16];
   assign irq_edge  = bus.interrupt & ~int_q;
   assign read_busy = rd_frame & ((state == SEND_ADDR) || (state == READ_BYTE) ||
                                  (state == LATCH) || (state == WAIT_CS));
   assign last_slot = (slot == 3'(NBYTES - 1));

   function automatic logic [AW-1:0] assemble(input logic [8*NBYTES-1:0] b);
      logic [AW-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_AXES; k++)
         r[16*k +: 16] = BIG_ENDIAN ? {b[16*k +: 8], b[16*k+8 +: 8]} : b[16*k +: 16];
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         slot        <= '0;
         rd_frame    <= 1'b0;
         byte_buf    <= '0;
         axis_q      <= '0;
         done_init_q <= 1'b0;
         pending     <= 1'b0;
         overrun_q   <= 1'b0;
         int_q       <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         slot        <= slot_n;
         rd_frame    <= rd_frame_n;
         byte_buf    <= byte_buf_n;
         axis_q      <= axis_n;
         done_init_q <= done_init_n;
         pending     <= pending_n;
         overrun_q   <= overrun_n;
         int_q       <= bus.interrupt;
      end
   end

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      slot_n      = slot;
      rd_frame_n  = rd_frame;
      byte_buf_n  = byte_buf;
      axis_n      = axis_q;
      done_init_n = done_init_q;
      pending_n   = pending;
      overrun_n   = overrun_q;
      bt          = 1'b0;
      dr          = 1'b0;
      sd          = 8'h00;

      // Only one burst is ever owed; a second edge before it is served is an overrun.
      if (irq_edge) begin
         pending_n = 1'b1;
         if (pending || read_busy)
            overrun_n = 1'b1;
      end

      case (state)
         IDLE: begin
            idx_n       = '0;
            slot_n      = '0;
            done_init_n = 1'b0;
            axis_n      = '0;
            overrun_n   = 1'b0;
            pending_n   = 1'b0;
            if (bus.start)
               state_n = INIT_LOAD;
         end
         INIT_LOAD: begin
            if (!bus.start) begin
               state_n = IDLE;
            end else if (idx == 4'(INIT_LEN)) begin
               done_init_n = 1'b1;
               state_n     = RUN;
               if (bus.interrupt)
                  pending_n = 1'b1;
            end else begin
               rd_frame_n = 1'b0;
               state_n    = SEND_ADDR;
            end
         end
         SEND_ADDR: begin
            bt = 1'b1;
            sd = rd_frame ? READ_ADDR : entry[15:8];
            if (bus.end_transmission) begin
               slot_n  = '0;
               state_n = rd_frame ? READ_BYTE : SEND_DATA;
            end
         end
         SEND_DATA: begin
            bt = 1'b1;
            sd = entry[7:0];
            if (bus.end_transmission)
               state_n = WAIT_CS;
         end
         READ_BYTE: begin
            bt = 1'b1;
            if (bus.end_transmission) begin
               for (int b = 0; b < NBYTES; b++)
                  if (slot == 3'(b))
                     byte_buf_n[8*b +: 8] = bus.received_data;
               if (last_slot) begin
                  axis_n  = assemble(byte_buf_n);
                  slot_n  = '0;
                  state_n = LATCH;
               end else begin
                  slot_n = slot + 3'd1;
               end
            end
         end
         LATCH: begin
            dr      = 1'b1;
            state_n = WAIT_CS;
         end
         WAIT_CS: begin
            if (bus.chip_select) begin
               if (!bus.start)
                  state_n = IDLE;
               else if (rd_frame)
                  state_n = RUN;
               else begin
                  idx_n   = idx + 4'd1;
                  state_n = INIT_LOAD;
               end
            end
         end
         RUN: begin
            if (!bus.start) begin
               state_n = IDLE;
            end else if (pending) begin
               sd         = READ_ADDR;
               pending_n  = irq_edge;
               rd_frame_n = 1'b1;
               state_n    = SEND_ADDR;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.begin_transmission = bt;
   assign bus.send_data          = sd;
   assign bus.done_init          = done_init_q;
   assign bus.done_read          = dr;
   assign bus.axis_data          = axis_q;
   assign bus.overrun            = overrun_q;

`ifdef IMU_SAMPLE_COUNT_EN
   logic [15:0] sample_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sample_cnt <= '0;
      else if (state == IDLE)
         sample_cnt <= '0;
      else if (dr)
         sample_cnt <= sample_cnt + 16'd1;
   end

   assign sample_count = sample_cnt;
`endif

endmodule
